// File: rtl/memory1_stage.sv
// memory1_stage: first memory pipeline stage. Holds one instruction, checks alignment,
// issues a single data-cache request per memory op and forwards ALU results to execute.
// Optional feature macro: MEM1_ALE_CHECK_EN (alignment exceptions instead of address masking).

package memory1_stage_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    localparam logic [5:0] ECODE_ALE = 6'h09;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] ex_out;
        logic [31:0] rkd_data;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic        is_mem;
        logic        is_store;
        mem_size_e   mem_size;
        logic        mem_signed;
    } execute_memory1_pass_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] ex_out;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic        is_mem;
        logic        is_store;
        mem_size_e   mem_size;
        logic        mem_signed;
    } memory1_memory2_pass_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  ecode;
        logic [31:0] badv;
    } excp_pass_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic [31:0] data;
    } forward_req_t;

endpackage

module memory1_stage
    import memory1_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  next_rdy_in,
    output logic                  rdy_in,
    input  execute_memory1_pass_t pass_in,
    input  excp_pass_t            excp_pass_in,
    output memory1_memory2_pass_t pass_out,
    output excp_pass_t            excp_pass_out,
    output forward_req_t          mem1_req,
    output logic                  dc_req_valid,
    input  logic                  dc_req_rdy,
    output logic [ADDR_W-1:0]     dc_addr,
    output logic                  dc_is_store,
    output logic [31:0]           dc_wdata,
    output logic [3:0]            dc_wstrb
);

    // ST_OPEN: no request accepted yet for the held instruction; ST_ISSUED: accepted.
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_ISSUED = 1'b1
    } req_state_e;

    execute_memory1_pass_t r_q, r_d;
    excp_pass_t            excp_q, excp_d;
    req_state_e            state_q, state_d;

    logic [31:0] a;
    logic [31:0] addr_eff;
    logic        ale;
    logic        need_req;
    logic        issued;
    logic        m1_flush;
    logic        m1_stall;
`ifdef MEM1_ALE_CHECK_EN
    logic        misaligned;
`endif

    // Alignment, request, stall and output datapath
    always_comb begin
        a = r_q.ex_out;
`ifdef MEM1_ALE_CHECK_EN
        misaligned = 1'b0;
        case (r_q.mem_size)
            MEM_HALF: misaligned = a[0];
            MEM_WORD: misaligned = |a[1:0];
            default:  misaligned = 1'b0;
        endcase
        ale      = misaligned & r_q.is_mem;
        addr_eff = a;
`else
        ale      = 1'b0;
        addr_eff = a;
        case (r_q.mem_size)
            MEM_HALF: addr_eff[0]   = 1'b0;
            MEM_WORD: addr_eff[1:0] = 2'b00;
            default:  addr_eff      = a;
        endcase
`endif

        // Bubbles carry stale fields, so the request is gated by valid as well.
        need_req = r_q.valid & r_q.is_mem & ~excp_q.valid & ~ale;
        issued   = (state_q == ST_ISSUED);
        m1_flush = flush | ~r_q.valid;
        m1_stall = ~next_rdy_in | (need_req & ~issued & ~dc_req_rdy);
        rdy_in   = m1_flush | ~m1_stall;

        dc_req_valid = need_req & ~issued & ~flush;
        dc_addr      = ADDR_W'(addr_eff);
        dc_is_store  = r_q.is_store;
        case (r_q.mem_size)
            MEM_BYTE: begin
                dc_wstrb = 4'b0001 << addr_eff[1:0];
                dc_wdata = {4{r_q.rkd_data[7:0]}};
            end
            MEM_HALF: begin
                dc_wstrb = 4'b0011 << addr_eff[1:0];
                dc_wdata = {2{r_q.rkd_data[15:0]}};
            end
            default: begin
                dc_wstrb = 4'hF;
                dc_wdata = r_q.rkd_data;
            end
        endcase
        if (!r_q.is_store) begin
            dc_wstrb = 4'h0;
        end

        pass_out.valid             = ~m1_flush & ~m1_stall;
        pass_out.pc                = r_q.pc;
        pass_out.pc_plus4          = r_q.pc_plus4;
        pass_out.ex_out            = r_q.ex_out;
        pass_out.rd                = r_q.rd;
        pass_out.is_wr_rd          = r_q.is_wr_rd;
        pass_out.is_wr_rd_pc_plus4 = r_q.is_wr_rd_pc_plus4;
        pass_out.is_mem            = r_q.is_mem;
        pass_out.is_store          = r_q.is_store;
        pass_out.mem_size          = r_q.mem_size;
        pass_out.mem_signed        = r_q.mem_signed;

        // An upstream exception takes priority over a local alignment fault.
        excp_pass_out = excp_q;
        if (!excp_q.valid && ale) begin
            excp_pass_out.valid = 1'b1;
            excp_pass_out.ecode = ECODE_ALE;
            excp_pass_out.badv  = a;
        end

        mem1_req.valid = r_q.valid & r_q.is_wr_rd & ~r_q.is_mem & (r_q.rd != 5'd0);
        mem1_req.idx   = r_q.rd;
        mem1_req.data  = r_q.is_wr_rd_pc_plus4 ? r_q.pc_plus4 : r_q.ex_out;
    end

    // Input register load and request-state next state
    always_comb begin
        r_d     = r_q;
        excp_d  = excp_q;
        state_d = state_q;
        if (rdy_in) begin
            r_d     = pass_in;
            excp_d  = excp_pass_in;
            state_d = ST_OPEN;
        end else if (dc_req_valid && dc_req_rdy) begin
            state_d = ST_ISSUED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= '0;
            excp_q  <= '0;
            state_q <= ST_OPEN;
        end else begin
            r_q     <= r_d;
            excp_q  <= excp_d;
            state_q <= state_d;
        end
    end

endmodule
